// File: rtl/stop_watch_disp.sv
// Six-digit multiplexed 7-segment driver for the stop_watch hh.mm.ss output.
// A shadow register captures the digits once per frame so each scan is a coherent snapshot.
module stop_watch_disp #(
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] hr_h,
  input  logic [3:0] hr_l,
  input  logic [3:0] min_h,
  input  logic [3:0] min_l,
  input  logic [3:0] sec_h,
  input  logic [3:0] sec_l,
  input  logic       blank_lead,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] dig_sel,
  output logic       frame_tick
);

  localparam int              PW      = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]   P_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]   P_BLANK = PW'(BLANK_CYC);
  localparam logic [6:0]      SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic            DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [5:0]      DIG_OFF = {6{DIG_ACTIVE_LOW}};

  // Slot encoding doubles as the index into the shadow digit array and dig_sel.
  typedef enum logic [2:0] {
    SLOT_SEC_L = 3'd0,
    SLOT_SEC_H = 3'd1,
    SLOT_MIN_L = 3'd2,
    SLOT_MIN_H = 3'd3,
    SLOT_HR_L  = 3'd4,
    SLOT_HR_H  = 3'd5
  } slot_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic [PW-1:0]   p_q, p_d;
  slot_e           i_q, i_d;
  logic [5:0][3:0] shadow_q, shadow_d;
  logic            blank_lead_q, blank_lead_d;
  logic            load;

  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [5:0]      dig_q, dig_d;
  logic            frame_tick_q;

  logic            p_wrap;
  logic            dig_on;
  logic [3:0]      digit;
  logic [6:0]      seg_raw;

  // Scan counters and snapshot load.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    p_wrap       = (p_q == P_LAST);
    p_d          = p_wrap ? '0 : p_q + PW'(1);
    i_d          = i_q;
    load         = 1'b0;
    if (p_wrap) begin
      if (i_q == SLOT_HR_H) begin
        i_d  = SLOT_SEC_L;
        load = 1'b1;
      end else begin
        i_d  = slot_e'(i_q + 3'd1);
      end
    end
    shadow_d     = load ? {hr_h, hr_l, min_h, min_l, sec_h, sec_l} : shadow_q;
    blank_lead_d = load ? blank_lead : blank_lead_q;
  end

  // Outputs are decoded from next-state values so they line up with p/i on the same edge.
  always_comb begin
    dig_on  = (p_d >= P_BLANK);
    digit   = shadow_d[i_d];
    seg_raw = seg_decode(digit);
    if (i_d == SLOT_HR_H && blank_lead_d && digit == 4'd0) begin
      seg_raw = 7'h00;
    end
    seg_d = {7{SEG_ACTIVE_LOW}} ^ (dig_on ? seg_raw : 7'h00);
    dp_d  = SEG_ACTIVE_LOW ^ (dig_on && (i_d == SLOT_MIN_L || i_d == SLOT_HR_L));
    dig_d = {6{DIG_ACTIVE_LOW}} ^ (dig_on ? (6'b000001 << i_d) : 6'b000000);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      p_q          <= '0;
      i_q          <= SLOT_SEC_L;
      shadow_q     <= '0;
      blank_lead_q <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      dig_q        <= DIG_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      p_q          <= p_d;
      i_q          <= i_d;
      shadow_q     <= shadow_d;
      blank_lead_q <= blank_lead_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      dig_q        <= dig_d;
      frame_tick_q <= load;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign dig_sel    = dig_q;
  assign frame_tick = frame_tick_q;

endmodule
